// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package disp_pkg;

  typedef enum logic [1:0] {
    DIG_L   = 2'd0,
    BLANK_L = 2'd1,
    DIG_R   = 2'd2,
    BLANK_R = 2'd3
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [1:0] DIG_NONE  = 2'b00;
  localparam logic [1:0] DIG_LEFT  = 2'b10;
  localparam logic [1:0] DIG_RIGHT = 2'b01;

  function automatic disp_state_e next_state(input disp_state_e s);
    case (s)
      DIG_L:   return BLANK_L;
      BLANK_L: return DIG_R;
      DIG_R:   return BLANK_R;
      default: return DIG_L;
    endcase
  endfunction

endpackage

// File: rtl/disp_stab_filter.sv
// Stability filter: a pattern becomes pending only after it has been held
// unchanged for STABLE_CYC+1 edges and differs from what is on display.
module disp_stab_filter
  import disp_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] disp_in,
  input  logic [13:0] shadow,
  output logic        pending,
  output logic [13:0] cand
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYC);

  logic [13:0]   cand_q, cand_d;
  logic [CW-1:0] stab_cnt_q, stab_cnt_d;

  always_comb begin
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (disp_in != cand_q) begin
      cand_d     = disp_in;
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign pending = (stab_cnt_q == STAB_MAX) && (cand_q != shadow);
  assign cand    = cand_q;

endmodule

// File: rtl/disp_scan_2dig.sv
// Time-multiplexes a two-digit 7-segment pattern onto one shared bus with
// blanking dead-time; the displayed pattern only changes at frame start.
module disp_scan_2dig
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int STABLE_CYC = 4
) (
  input  logic        CLK_in,
  input  logic        RST_n_in,
  input  logic [13:0] Disp_in,
  input  logic        En_in,
  output logic [6:0]  Seg_out,
  output logic [1:0]  Dig_out,
  output logic        Upd_out
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  disp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, state_last;
  logic [13:0]      shadow_q, shadow_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_q, dig_d;
  logic             upd_q, upd_d;
  logic             pending;
  logic [13:0]      cand;

  disp_stab_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filter (
    .clk    (CLK_in),
    .rst_n  (RST_n_in),
    .disp_in(Disp_in),
    .shadow (shadow_q),
    .pending(pending),
    .cand   (cand)
  );

  // Outputs are derived from the next state so they are valid in a state's first cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    upd_d      = 1'b0;
    seg_d      = SEG_BLANK;
    dig_d      = DIG_NONE;
    state_last = ((state_q == DIG_L) || (state_q == DIG_R)) ? SCAN_LAST : BLANK_LAST;

    if (!En_in) begin
      state_d = BLANK_R;
      cnt_d   = '0;
    end else if (cnt_q == state_last) begin
      state_d = next_state(state_q);
      cnt_d   = '0;
      if ((state_q == BLANK_R) && pending) begin
        shadow_d = cand;
        upd_d    = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_d)
      DIG_L: begin
        seg_d = shadow_d[13:7];
        dig_d = DIG_LEFT;
      end
      DIG_R: begin
        seg_d = shadow_d[6:0];
        dig_d = DIG_RIGHT;
      end
      default: begin
        seg_d = SEG_BLANK;
        dig_d = DIG_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (!RST_n_in) begin
      state_q  <= BLANK_R;
      cnt_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      dig_q    <= DIG_NONE;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      upd_q    <= upd_d;
    end
  end

  assign Seg_out = seg_q;
  assign Dig_out = dig_q;
  assign Upd_out = upd_q;

endmodule
